// File: rtl/fpu_round_sched_if.sv
// Handshake bundle for the FPU round-stage scheduler: both producer pipes, the shared rounding datapath and the result FIFO.
// The sticky flag output exists only when FPU_ROUND_SCHED_STICKY_FLAGS_EN is defined.
interface fpu_round_sched_if #(parameter int TAG_W = 4);
   logic               req0_valid;
   logic               req0_ready;
   logic               req0_p_op;
   logic [117:0]       req0_data;
   logic [TAG_W-1:0]   req0_tag;
   logic               req1_valid;
   logic               req1_ready;
   logic               req1_p_op;
   logic [117:0]       req1_data;
   logic [TAG_W-1:0]   req1_tag;
   logic               rnd_p_op;
   logic [117:0]       rnd_din;
   logic [63:0]        rnd_dout;
   logic               rnd_overflow;
   logic               rnd_underflow;
   logic               rnd_inexact;
   logic               res_valid;
   logic               res_ready;
   logic [63:0]        res_data;
   logic               res_src;
   logic [TAG_W-1:0]   res_tag;
   logic [2:0]         res_flags;
   logic               flags_clr;
`ifdef FPU_ROUND_SCHED_STICKY_FLAGS_EN
   logic [2:0]         fflags;
`endif

   // master is the scheduler itself; slave is the surrounding pipes, datapath and consumer
   modport master (
`ifdef FPU_ROUND_SCHED_STICKY_FLAGS_EN
      output fflags,
`endif
      input  req0_valid, req0_p_op, req0_data, req0_tag,
      output req0_ready,
      input  req1_valid, req1_p_op, req1_data, req1_tag,
      output req1_ready,
      output rnd_p_op, rnd_din,
      input  rnd_dout, rnd_overflow, rnd_underflow, rnd_inexact,
      output res_valid, res_data, res_src, res_tag, res_flags,
      input  res_ready, flags_clr
   );

   modport slave (
`ifdef FPU_ROUND_SCHED_STICKY_FLAGS_EN
      input  fflags,
`endif
      output req0_valid, req0_p_op, req0_data, req0_tag,
      input  req0_ready,
      output req1_valid, req1_p_op, req1_data, req1_tag,
      input  req1_ready,
      input  rnd_p_op, rnd_din,
      output rnd_dout, rnd_overflow, rnd_underflow, rnd_inexact,
      input  res_valid, res_data, res_src, res_tag, res_flags,
      output res_ready, flags_clr
   );
endinterface

// File: rtl/fpu_round_sched.sv
// Round-robin scheduler for the shared rounding datapath with a 2-entry result FIFO.
// Define FPU_ROUND_SCHED_STICKY_FLAGS_EN to add the sticky fflags register and honour flags_clr.
module fpu_round_sched #(
   parameter int TAG_W = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   fpu_round_sched_if.master   bus
);

   typedef struct packed {
      logic [63:0]      data;
      logic             src;
      logic [TAG_W-1:0] tag;
      logic [2:0]       flags;
   } entry_t;

   entry_t       fifo_q [2];
   entry_t       wrEntry;
   entry_t       headEntry;
   logic [1:0]   count_q;
   logic [1:0]   count_d;
   logic         wptr_q;
   logic         rptr_q;
   logic         lastGrant_q;
   logic         canAccept;
   logic         grant0;
   logic         grant1;
   logic         accept;
   logic         pop;
   logic [2:0]   rndFlags;

   // Readiness depends only on registered occupancy, so res_ready never reaches req*_ready.
   always_comb begin
      canAccept = (count_q != 2'd2);
      grant0    = bus.req0_valid & (~bus.req1_valid | lastGrant_q);
      grant1    = bus.req1_valid & ~grant0;
      accept    = (grant0 | grant1) & canAccept;
      pop       = (count_q != 2'd0) & bus.res_ready;
      count_d   = count_q + {1'b0, accept} - {1'b0, pop};
      rndFlags  = {bus.rnd_overflow, bus.rnd_underflow, bus.rnd_inexact};
      wrEntry   = {bus.rnd_dout, grant1, (grant1 ? bus.req1_tag : bus.req0_tag), rndFlags};
      headEntry = fifo_q[rptr_q];
   end

   assign bus.req0_ready = grant0 & canAccept;
   assign bus.req1_ready = grant1 & canAccept;
   assign bus.rnd_p_op   = accept & (grant1 ? bus.req1_p_op : bus.req0_p_op);
   assign bus.rnd_din    = accept ? (grant1 ? bus.req1_data : bus.req0_data) : '0;

   assign bus.res_valid  = (count_q != 2'd0);
   assign bus.res_data   = headEntry.data;
   assign bus.res_src    = headEntry.src;
   assign bus.res_tag    = headEntry.tag;
   assign bus.res_flags  = headEntry.flags;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            fifo_q[i] <= '0;
         end
         count_q     <= 2'd0;
         wptr_q      <= 1'b0;
         rptr_q      <= 1'b0;
         lastGrant_q <= 1'b1;
      end else begin
         if (accept) begin
            fifo_q[wptr_q] <= wrEntry;
            wptr_q         <= ~wptr_q;
            lastGrant_q    <= grant1;
         end
         if (pop) begin
            rptr_q <= ~rptr_q;
         end
         count_q <= count_d;
      end
   end

`ifdef FPU_ROUND_SCHED_STICKY_FLAGS_EN
   logic [2:0] fflags_q;
   logic [2:0] fflags_d;

   // A clear that collides with an accept keeps the newly accepted flags.
   always_comb begin
      fflags_d = (bus.flags_clr ? 3'b000 : fflags_q) | (accept ? rndFlags : 3'b000);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fflags_q <= 3'b000;
      end else begin
         fflags_q <= fflags_d;
      end
   end

   assign bus.fflags = fflags_q;
`else
   logic unusedFlagsClr;
   assign unusedFlagsClr = bus.flags_clr;
`endif

endmodule

// File: tb/tb_fpu_round_sched.sv
// Scoreboard bench for fpu_round_sched: random and directed traffic against an arbitration/FIFO reference model.
// Sticky-flag checks are compiled in only when FPU_ROUND_SCHED_STICKY_FLAGS_EN is defined.
module tb_fpu_round_sched;
   localparam int TAG_W = 4;

   typedef struct packed {
      logic [63:0]      data;
      logic             src;
      logic [TAG_W-1:0] tag;
      logic [2:0]       flags;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fpu_round_sched_if #(.TAG_W(TAG_W)) bus ();
   fpu_round_sched #(.TAG_W(TAG_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int   checks = 0;
   int   passes = 0;
   exp_t expQ [$];

   int         modelCount;
   bit         modelLast;
   logic [2:0] modelFflags;
   int         accCnt [2];
   int         seenCnt [2];

   bit               reqValid [2];
   bit               reqPop [2];
   logic [117:0]     reqData [2];
   logic [TAG_W-1:0] reqTag [2];

   // Behavioural stand-in for the rounding datapath: truncate each lane to single precision.
   function automatic logic [31:0] laneRound(input logic [58:0] l);
      return {l[58], l[55:48], l[46:24]};
   endfunction

   function automatic logic [2:0] laneFlags(input logic [58:0] l);
      logic [9:0]  e;
      logic [47:0] f;
      e = l[57:48];
      f = l[47:0];
      return {(e >= 10'h0FF), ((e == 10'h000) && (f != 48'h0)), (f[23:0] != 24'h0)};
   endfunction

   function automatic logic [63:0] roundData(input logic p, input logic [117:0] d);
      return {(p ? laneRound(d[117:59]) : 32'h0), laneRound(d[58:0])};
   endfunction

   function automatic logic [2:0] roundFlags(input logic p, input logic [117:0] d);
      return laneFlags(d[58:0]) | (p ? laneFlags(d[117:59]) : 3'b000);
   endfunction

   always_comb begin
      bus.rnd_dout = roundData(bus.rnd_p_op, bus.rnd_din);
      {bus.rnd_overflow, bus.rnd_underflow, bus.rnd_inexact} = roundFlags(bus.rnd_p_op, bus.rnd_din);
   end

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act === req) passes++;
      else $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
   endtask

   // Reference model: round-robin grant, 2-deep occupancy and sticky flags, sampled mid-cycle.
   int          g;
   bit          acc;
   bit          popNow;
   logic        gPop;
   logic [117:0] gData;
   logic [TAG_W-1:0] gTag;
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.req0_valid && bus.req1_valid) g = modelLast ? 0 : 1;
         else if (bus.req0_valid) g = 0;
         else if (bus.req1_valid) g = 1;
         else g = -1;
         acc    = (g >= 0) && (modelCount != 2);
         popNow = (modelCount != 0) && bus.res_ready;
         gPop   = (g == 1) ? bus.req1_p_op : bus.req0_p_op;
         gData  = (g == 1) ? bus.req1_data : bus.req0_data;
         gTag   = (g == 1) ? bus.req1_tag  : bus.req0_tag;
         checkOutput("req0_ready", bus.req0_ready, acc && (g == 0));
         checkOutput("req1_ready", bus.req1_ready, acc && (g == 1));
         checkOutput("rnd_din", bus.rnd_din, acc ? gData : 118'h0);
         checkOutput("rnd_p_op", bus.rnd_p_op, acc ? gPop : 1'b0);
         checkOutput("res_valid", bus.res_valid, modelCount != 0);
`ifdef FPU_ROUND_SCHED_STICKY_FLAGS_EN
         checkOutput("fflags", bus.fflags, modelFflags);
`endif
         modelFflags = (bus.flags_clr ? 3'b000 : modelFflags) | (acc ? roundFlags(gPop, gData) : 3'b000);
         if (acc) begin
            expQ.push_back({roundData(gPop, gData), (g == 1), gTag, roundFlags(gPop, gData)});
            modelLast = (g == 1);
            accCnt[g] = accCnt[g] + 1;
         end
         modelCount = modelCount + int'(acc) - int'(popNow);
      end
   end

   // Monitor: every popped head is compared against the oldest expected entry.
   exp_t headExp;
   always @(negedge clk) begin
      if (rst_n && bus.res_valid && bus.res_ready) begin
         if (expQ.size() == 0) begin
            checks++;
            $display("[TB] FAIL pop_empty: actual=res_valid 1 required=no pending result");
         end else begin
            headExp = expQ.pop_front();
            checkOutput("res_data", bus.res_data, headExp.data);
            checkOutput("res_src", bus.res_src, headExp.src);
            checkOutput("res_tag", bus.res_tag, headExp.tag);
            checkOutput("res_flags", bus.res_flags, headExp.flags);
         end
      end
   end

   function automatic logic [58:0] randLane();
      logic [63:0] r;
      logic [9:0]  e;
      r = {$urandom, $urandom};
      e = 10'($urandom_range(300));
      if ($urandom_range(2) == 0) r[23:0] = 24'h0;
      return {r[63], e, r[47:0]};
   endfunction

   task automatic drive();
      bus.req0_valid = reqValid[0];
      bus.req0_p_op  = reqPop[0];
      bus.req0_data  = reqData[0];
      bus.req0_tag   = reqTag[0];
      bus.req1_valid = reqValid[1];
      bus.req1_p_op  = reqPop[1];
      bus.req1_data  = reqData[1];
      bus.req1_tag   = reqTag[1];
   endtask

   task automatic setReq(input int r, input logic p, input logic [117:0] d, input logic [TAG_W-1:0] t);
      reqValid[r] = 1'b1;
      reqPop[r]   = p;
      reqData[r]  = d;
      reqTag[r]   = t;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      for (int r = 0; r < 2; r++) begin
         if (accCnt[r] != seenCnt[r]) begin
            seenCnt[r]  = accCnt[r];
            reqValid[r] = 1'b0;
         end
      end
   endtask

   task automatic applyStimulus(input int cycles, input int pValid, input int pReady, input int pClr);
      for (int c = 0; c < cycles; c++) begin
         step();
         for (int r = 0; r < 2; r++) begin
            if (!reqValid[r] && ($urandom_range(99) < pValid))
               setReq(r, 1'($urandom_range(1)), {randLane(), randLane()}, TAG_W'($urandom));
         end
         bus.res_ready = ($urandom_range(99) < pReady);
         bus.flags_clr = ($urandom_range(99) < pClr);
         drive();
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      bus.res_ready = 1'b1;
      bus.flags_clr = 1'b0;
      while ((reqValid[0] || reqValid[1] || expQ.size() != 0 || modelCount != 0) && n < 30) begin
         step();
         drive();
         n++;
      end
      checkOutput("drain_pending", expQ.size(), 0);
   endtask

   initial begin
      modelCount  = 0;
      modelLast   = 1'b1;
      modelFflags = 3'b000;
      for (int r = 0; r < 2; r++) begin
         accCnt[r] = 0; seenCnt[r] = 0; reqValid[r] = 1'b0;
         reqPop[r] = 1'b0; reqData[r] = '0; reqTag[r] = '0;
      end
      drive();
      bus.res_ready = 1'b0;
      bus.flags_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_res_valid", bus.res_valid, 1'b0);
      checkOutput("rst_res_data", bus.res_data, 64'h0);
      checkOutput("rst_res_tag", bus.res_tag, 0);
      checkOutput("rst_res_src", bus.res_src, 1'b0);
      checkOutput("rst_rnd_din", bus.rnd_din, 118'h0);
`ifdef FPU_ROUND_SCHED_STICKY_FLAGS_EN
      checkOutput("rst_fflags", bus.fflags, 3'b000);
`endif
      rst_n = 1'b1;

      $display("[TB] single request latency");
      setReq(0, 1'b0, {59'h0, 1'b0, 10'h07F, 48'h800000000000}, 4'h5);
      bus.res_ready = 1'b1;
      drive();
      @(negedge clk);
      checkOutput("lat_ready", bus.req0_ready, 1'b1);
      step();
      checkOutput("lat_valid", bus.res_valid, 1'b1);
      checkOutput("lat_data", bus.res_data[31:0], 32'h3F800000);
      checkOutput("lat_src", bus.res_src, 1'b0);
      checkOutput("lat_flags", bus.res_flags, 3'b000);
      drive();

      $display("[TB] round-robin with both requesters saturated");
      applyStimulus(20, 100, 100, 0);

      $display("[TB] backpressure then async reset at full");
      applyStimulus(8, 100, 0, 0);
      checkOutput("bp_full_valid", bus.res_valid, 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_mid_valid", bus.res_valid, 1'b0);
      expQ.delete();
      modelCount  = 0;
      modelLast   = 1'b1;
      modelFflags = 3'b000;
      for (int r = 0; r < 2; r++) seenCnt[r] = accCnt[r];
      setReq(0, 1'b0, {randLane(), randLane()}, 4'h3);
      setReq(1, 1'b1, {randLane(), randLane()}, 4'hC);
      drive();
      step();
      step();
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("post_rst_grant0", bus.req0_ready, 1'b1);
      checkOutput("post_rst_grant1", bus.req1_ready, 1'b0);
      drain();

      $display("[TB] overflow flag and sticky clear collision");
      setReq(1, 1'b1, {1'b0, 10'h0FF, 48'h800000000000, 1'b0, 10'h07F, 48'h800000000000}, 4'hA);
      drive();
      step();
      drive();
      checkOutput("ovf_res_flags", bus.res_flags, 3'b100);
      step();
      step();
`ifdef FPU_ROUND_SCHED_STICKY_FLAGS_EN
      checkOutput("ovf_sticky", bus.fflags, 3'b100);
`endif
      setReq(0, 1'b0, {59'h0, 1'b0, 10'h07F, 48'h800000000001}, 4'h6);
      bus.flags_clr = 1'b1;
      drive();
      step();
      bus.flags_clr = 1'b0;
      drive();
`ifdef FPU_ROUND_SCHED_STICKY_FLAGS_EN
      checkOutput("clr_collision", bus.fflags, 3'b001);
`endif
      checkOutput("clr_res_flags", bus.res_flags, 3'b001);

      $display("[TB] randomized traffic");
      applyStimulus(300, 60, 70, 5);
      drain();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout: actual=still running required=finished");
      $fatal(1, "[TB] timeout");
   end
endmodule
